ahb_slave_if: RTL and testbench
===============================

Name: ahb_slave_if

Overview:
- AHB-Lite responder (slave interface) for the AHB-to-APB bridge; it is the counterpart of the AHB master stimulus block.
- Decodes address-phase transfers into three peripheral regions and pipelines address/control into the data phase.
- Issues a single req/ack transaction to the bridge back end, which is the APB controller.
- Inserts wait states on Hreadyout until the back end acknowledges, and returns read data plus an OKAY/ERROR response.

Parameters:
- DATA_W, 32, width of the data buses.
- TIMEOUT_CYC, 16, back-end ack timeout in cycles. Used only with AHB_SLV_TIMEOUT_EN.

Ports:
- Hclk  in  1  bus clock; all state updates on its rising edge.
- Hresetn  in  1  asynchronous active-low reset.
- Hwrite  in  1  1=write, 0=read; address-phase control.
- Hreadyin  in  1  previous transfer complete; qualifies the address phase.
- Htrans  in  2  0=IDLE, 1=BUSY, 2=NONSEQ, 3=SEQ.
- Haddr  in  32  transfer address.
- Hwdata  in  DATA_W  write data, valid in the data phase.
- Hrdata  out  DATA_W  read data, registered.
- Hreadyout  out  1  data-phase done; 0 = wait state.
- Hresp  out  2  0=OKAY, 1=ERROR.
- bk_req  out  1  back-end request, held until bk_ack.
- bk_write  out  1  back-end direction.
- bk_addr  out  32  back-end address.
- bk_wdata  out  DATA_W  back-end write data.
- bk_sel  out  3  one-hot region select.
- bk_ack  in  1  back end done, one-cycle pulse.
- bk_rdata  in  DATA_W  read data, valid with bk_ack.

Behaviour:
- Reset: one clock (Hclk); reset Hresetn is asynchronous, active-low. It clears immediately, independent of Hclk.
  - State=IDLE, Hreadyout=1, Hresp=0, Hrdata=0, bk_req=0, bk_write=0, bk_addr=0, bk_wdata=0, bk_sel=0.
  - Reset mid-transaction drops bk_req at once; any pending transfer is discarded.
- Valid transfer: Hreadyin=1 and Htrans is 2 or 3.
- Address map, decoded on Haddr[31:24]:
  - 0x80–0x83 gives bk_sel=001.
  - 0x84–0x87 gives bk_sel=010.
  - 0x88–0x8B gives bk_sel=100.
  - Anything else is out of range.
- Htrans IDLE/BUSY: no action; zero-wait OKAY response.
- FSM states:
  - IDLE: Hreadyout=1, Hresp=0.
    - Valid and in range: latch Haddr, Hwrite, bk_sel; go to DPHASE.
    - Valid and out of range: go to ERR1.
  - DPHASE: Hreadyout=0. At the cycle-end edge, capture Hwdata into bk_wdata (writes only), set bk_req=1, go to REQ.
  - REQ: Hreadyout=0, bk_req=1.
    - On bk_ack: bk_req=0; for reads Hrdata<=bk_rdata; go to DONE.
  - DONE: Hreadyout=1, Hresp=0 for exactly one cycle. The address phase is pipelined here:
    - Valid and in range: accept, go to DPHASE.
    - Valid and out of range: go to ERR1.
    - Otherwise: go to IDLE.
  - ERR1: Hreadyout=0, Hresp=1 → ERR2.
  - ERR2: Hreadyout=1, Hresp=1 → IDLE. Transfers presented during ERR2 are ignored; the master cancels them.
- Latency: with bk_ack in the first REQ cycle, the data phase lasts 3 cycles (DPHASE, REQ, DONE). Each extra cycle of ack delay adds one wait state.
- Hrdata holds its value until the next read completes; write transfers do not alter it.
- bk_ack outside REQ is ignored.
- bk_addr, bk_write, bk_sel stay stable for the entire time bk_req=1.

Optional Feature:
- Macro AHB_SLV_TIMEOUT_EN.
- With the macro: a counter runs in REQ and is cleared on entry to REQ. If TIMEOUT_CYC cycles pass without bk_ack, bk_req drops and the FSM goes to ERR1, signalling an ERROR response. A bk_ack arriving on the timeout cycle wins and the transfer completes OKAY.
- Without the macro: REQ waits indefinitely and no counter is synthesised.

Decomposition:
- Package ahb_slv_pkg holds:
  - Htrans encodings (IDLE/BUSY/NONSEQ/SEQ).
  - Hresp codes.
  - FSM state enum.
  - Region base/limit constants and bk_sel one-hot values.
- Sub-module ahb_addr_decode: combinational; maps Haddr to bk_sel and an out-of-range flag. It is instantiated once.

Test Plan:
- Single write: Haddr=0x80000001, Hwrite=1, Htrans=2, Hwdata=0x80 in the data phase, bk_ack in the first REQ cycle.
  - Expect bk_sel=001, bk_addr=0x80000001, bk_wdata=0x80, bk_req high for 1 cycle.
  - Expect Hreadyout low for 2 cycles, then high, with Hresp=0.
- Single read: Haddr=0x84000010, bk_ack after 3 cycles with bk_rdata=0xA5.
  - Expect bk_sel=010, 4 wait states, Hrdata=0xA5 in DONE.
- INCR4 burst write at 0x80000001 (NONSEQ then 3×SEQ, immediate ack).
  - Expect 4 back-end requests at addresses 01..04 in order.
  - Expect each next address accepted in DONE, with no IDLE cycles in between.
- Out-of-range: Haddr=0x90000000, Htrans=2.
  - Expect no bk_req, Hresp=1 for 2 cycles, Hreadyout pattern 0 then 1.
- Reset mid-REQ: Hresetn=0 while bk_req=1.
  - Expect bk_req=0 and Hreadyout=1 immediately, without waiting for a clock edge.
  - Expect the next transfer after reset release to behave normally.
- Timeout (AHB_SLV_TIMEOUT_EN, TIMEOUT_CYC=16): bk_ack never asserted.
  - Expect bk_req to drop after 16 REQ cycles, followed by a two-cycle ERROR response.

Source files
------------

// File: rtl/ahb_slv_pkg.sv
// rtl/ahb_slv_pkg.sv - shared encodings, FSM states and address map for the AHB slave interface
package ahb_slv_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'd0,
        HTRANS_BUSY   = 2'd1,
        HTRANS_NONSEQ = 2'd2,
        HTRANS_SEQ    = 2'd3
    } htrans_e;

    localparam logic [1:0] HRESP_OKAY  = 2'd0;
    localparam logic [1:0] HRESP_ERROR = 2'd1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_DPHASE = 3'd1,
        S_REQ    = 3'd2,
        S_DONE   = 3'd3,
        S_ERR1   = 3'd4,
        S_ERR2   = 3'd5
    } state_e;

    // Regions are decoded on Haddr[31:24] only
    localparam logic [7:0] REG0_BASE  = 8'h80;
    localparam logic [7:0] REG0_LIMIT = 8'h83;
    localparam logic [7:0] REG1_BASE  = 8'h84;
    localparam logic [7:0] REG1_LIMIT = 8'h87;
    localparam logic [7:0] REG2_BASE  = 8'h88;
    localparam logic [7:0] REG2_LIMIT = 8'h8B;

    localparam logic [2:0] SEL_NONE = 3'b000;
    localparam logic [2:0] SEL_REG0 = 3'b001;
    localparam logic [2:0] SEL_REG1 = 3'b010;
    localparam logic [2:0] SEL_REG2 = 3'b100;

endpackage

// File: rtl/ahb_addr_decode.sv
// rtl/ahb_addr_decode.sv - combinational region decode of the upper address byte
module ahb_addr_decode
    import ahb_slv_pkg::*;
(
    input  logic [7:0] addr_hi,
    output logic [2:0] sel,
    output logic       out_of_range
);

    always_comb begin
        sel = SEL_NONE;
        if (addr_hi >= REG0_BASE && addr_hi <= REG0_LIMIT) begin
            sel = SEL_REG0;
        end else if (addr_hi >= REG1_BASE && addr_hi <= REG1_LIMIT) begin
            sel = SEL_REG1;
        end else if (addr_hi >= REG2_BASE && addr_hi <= REG2_LIMIT) begin
            sel = SEL_REG2;
        end
    end

    assign out_of_range = (sel == SEL_NONE);

endmodule

// File: rtl/ahb_slave_if.sv
// rtl/ahb_slave_if.sv - AHB-Lite responder issuing one req/ack back-end transaction per transfer
// Optional back-end ack timeout with AHB_SLV_TIMEOUT_EN.
module ahb_slave_if
    import ahb_slv_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic              Hclk,
    input  logic              Hresetn,
    input  logic              Hwrite,
    input  logic              Hreadyin,
    input  logic [1:0]        Htrans,
    input  logic [31:0]       Haddr,
    input  logic [DATA_W-1:0] Hwdata,
    output logic [DATA_W-1:0] Hrdata,
    output logic              Hreadyout,
    output logic [1:0]        Hresp,
    output logic              bk_req,
    output logic              bk_write,
    output logic [31:0]       bk_addr,
    output logic [DATA_W-1:0] bk_wdata,
    output logic [2:0]        bk_sel,
    input  logic              bk_ack,
    input  logic [DATA_W-1:0] bk_rdata
);

    state_e     state, next_state;
    logic [2:0] dec_sel;
    logic       dec_oor;
    logic       valid;
    logic       addr_phase;
    logic       accept;
    logic       timeout_hit;

    ahb_addr_decode u_decode (
        .addr_hi      (Haddr[31:24]),
        .sel          (dec_sel),
        .out_of_range (dec_oor)
    );

    assign valid      = Hreadyin && (Htrans == HTRANS_NONSEQ || Htrans == HTRANS_SEQ);
    assign addr_phase = (state == S_IDLE) || (state == S_DONE);
    assign accept     = addr_phase && valid && !dec_oor;

`ifdef AHB_SLV_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TO_W-1:0] to_cnt;

    // Held at zero outside REQ so every REQ entry starts a fresh count
    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            to_cnt <= '0;
        end else if (state != S_REQ) begin
            to_cnt <= '0;
        end else begin
            to_cnt <= to_cnt + 1'b1;
        end
    end

    assign timeout_hit = (state == S_REQ) && (to_cnt == TO_W'(TIMEOUT_CYC - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        next_state = state;
        Hreadyout  = 1'b1;
        Hresp      = HRESP_OKAY;
        case (state)
            S_IDLE, S_DONE: begin
                if (valid) next_state = dec_oor ? S_ERR1 : S_DPHASE;
                else       next_state = S_IDLE;
            end
            S_DPHASE: begin
                Hreadyout  = 1'b0;
                next_state = S_REQ;
            end
            S_REQ: begin
                Hreadyout = 1'b0;
                // A late ack on the timeout cycle still completes OKAY
                if (bk_ack)           next_state = S_DONE;
                else if (timeout_hit) next_state = S_ERR1;
            end
            S_ERR1: begin
                Hreadyout  = 1'b0;
                Hresp      = HRESP_ERROR;
                next_state = S_ERR2;
            end
            S_ERR2: begin
                Hresp      = HRESP_ERROR;
                next_state = S_IDLE;
            end
            default: next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            state    <= S_IDLE;
            bk_req   <= 1'b0;
            bk_write <= 1'b0;
            bk_addr  <= '0;
            bk_wdata <= '0;
            bk_sel   <= SEL_NONE;
            Hrdata   <= '0;
        end else begin
            state  <= next_state;
            bk_req <= (next_state == S_REQ);
            if (accept) begin
                bk_addr  <= Haddr;
                bk_write <= Hwrite;
                bk_sel   <= dec_sel;
            end
            if (state == S_DPHASE && bk_write) begin
                bk_wdata <= Hwdata;
            end
            if (state == S_REQ && bk_ack && !bk_write) begin
                Hrdata <= bk_rdata;
            end
        end
    end

endmodule

// File: tb/tb_ahb_slave_if.sv
// tb/tb_ahb_slave_if.sv - directed self-checking bench for ahb_slave_if
module tb_ahb_slave_if;

    localparam int DW = 32;

    logic          Hclk     = 1'b0;
    logic          Hresetn  = 1'b0;
    logic          Hwrite   = 1'b0;
    logic          Hreadyin = 1'b1;
    logic [1:0]    Htrans   = 2'd0;
    logic [31:0]   Haddr    = 32'h0;
    logic [DW-1:0] Hwdata   = '0;
    logic [DW-1:0] Hrdata;
    logic          Hreadyout;
    logic [1:0]    Hresp;
    logic          bk_req;
    logic          bk_write;
    logic [31:0]   bk_addr;
    logic [DW-1:0] bk_wdata;
    logic [2:0]    bk_sel;
    logic          bk_ack   = 1'b0;
    logic [DW-1:0] bk_rdata = '0;

    int checks   = 0;
    int failures = 0;
    int req_edges = 0;
    logic req_prev = 1'b0;

    ahb_slave_if #(.DATA_W(DW), .TIMEOUT_CYC(16)) dut (
        .Hclk      (Hclk),
        .Hresetn   (Hresetn),
        .Hwrite    (Hwrite),
        .Hreadyin  (Hreadyin),
        .Htrans    (Htrans),
        .Haddr     (Haddr),
        .Hwdata    (Hwdata),
        .Hrdata    (Hrdata),
        .Hreadyout (Hreadyout),
        .Hresp     (Hresp),
        .bk_req    (bk_req),
        .bk_write  (bk_write),
        .bk_addr   (bk_addr),
        .bk_wdata  (bk_wdata),
        .bk_sel    (bk_sel),
        .bk_ack    (bk_ack),
        .bk_rdata  (bk_rdata)
    );

    always #5 Hclk = ~Hclk;

    always @(negedge Hclk) begin
        if (bk_req && !req_prev) req_edges++;
        req_prev = bk_req;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge Hclk);
        #1;
    endtask

    initial begin
        int waits;
        int reqc;
        int n;
        int edges0;

        // reset state
        step();
        chk("rst_hreadyout", Hreadyout, 1);
        chk("rst_hresp", Hresp, 0);
        chk("rst_hrdata", Hrdata, 0);
        chk("rst_bk_req", bk_req, 0);
        chk("rst_bk_sel", bk_sel, 0);
        chk("rst_bk_addr", bk_addr, 0);
        chk("rst_bk_wdata", bk_wdata, 0);
        chk("rst_bk_write", bk_write, 0);
        step();
        Hresetn = 1'b1;

        // single write, immediate ack
        Haddr = 32'h8000_0001; Hwrite = 1'b1; Htrans = 2'd2;
        step();
        Htrans = 2'd0; Hwdata = 32'h80;
        chk("wr_dphase_rdy", Hreadyout, 0);
        chk("wr_sel", bk_sel, 3'b001);
        chk("wr_addr", bk_addr, 32'h8000_0001);
        chk("wr_dphase_req", bk_req, 0);
        step();
        chk("wr_req", bk_req, 1);
        chk("wr_req_rdy", Hreadyout, 0);
        chk("wr_wdata", bk_wdata, 32'h80);
        chk("wr_write", bk_write, 1);
        bk_ack = 1'b1;
        step();
        bk_ack = 1'b0;
        chk("wr_done_rdy", Hreadyout, 1);
        chk("wr_done_resp", Hresp, 0);
        chk("wr_done_req", bk_req, 0);
        step();

        // Hreadyin low and BUSY are not transfers
        Haddr = 32'h8000_0000; Htrans = 2'd2; Hreadyin = 1'b0;
        step();
        step();
        chk("nordy_ignored", Hreadyout, 1);
        chk("nordy_no_req", bk_req, 0);
        Hreadyin = 1'b1; Htrans = 2'd1;
        step();
        step();
        chk("busy_ignored", Hreadyout, 1);
        chk("busy_resp", Hresp, 0);
        Htrans = 2'd0;

        // single read, ack in third REQ cycle
        Haddr = 32'h8400_0010; Hwrite = 1'b0; Htrans = 2'd2;
        step();
        Htrans = 2'd0;
        chk("rd_sel", bk_sel, 3'b010);
        chk("rd_write", bk_write, 0);
        waits = 0; reqc = 0;
        while (!Hreadyout && waits < 20) begin
            waits++;
            if (bk_req) begin
                reqc++;
                bk_ack   = (reqc == 3);
                bk_rdata = (reqc == 3) ? 32'hA5 : 32'h5A;
            end
            step();
            bk_ack = 1'b0;
        end
        chk("rd_waits", waits, 4);
        chk("rd_hrdata", Hrdata, 32'hA5);
        chk("rd_resp", Hresp, 0);
        step();

        // ack outside REQ is ignored
        bk_ack = 1'b1; bk_rdata = 32'h1234;
        step();
        bk_ack = 1'b0;
        chk("stray_ack_hrdata", Hrdata, 32'hA5);
        chk("stray_ack_rdy", Hreadyout, 1);
        chk("stray_ack_req", bk_req, 0);

        // INCR4 write burst, next address accepted in DONE
        bk_rdata = 32'hDEAD_BEEF;
        edges0 = req_edges;
        Haddr = 32'h8000_0001; Hwrite = 1'b1; Htrans = 2'd2;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("burst_dphase_rdy", Hreadyout, 0);
            chk("burst_addr", bk_addr, 32'h8000_0001 + i);
            Hwdata = 32'h1000 + i;
            Haddr  = 32'h8000_0002 + i;
            Htrans = (i == 3) ? 2'd0 : 2'd3;
            step();
            chk("burst_req", bk_req, 1);
            chk("burst_wdata", bk_wdata, 32'h1000 + i);
            bk_ack = 1'b1;
            step();
            bk_ack = 1'b0;
            chk("burst_done_rdy", Hreadyout, 1);
        end
        step();
        chk("burst_req_count", req_edges - edges0, 4);
        chk("burst_hrdata_kept", Hrdata, 32'hA5);

        // out of range, transfer during ERR2 ignored
        Haddr = 32'h9000_0000; Hwrite = 1'b0; Htrans = 2'd2;
        step();
        Htrans = 2'd0;
        chk("oor_err1_rdy", Hreadyout, 0);
        chk("oor_err1_resp", Hresp, 1);
        chk("oor_no_req", bk_req, 0);
        Haddr = 32'h8000_0000; Htrans = 2'd2;
        step();
        chk("oor_err2_rdy", Hreadyout, 1);
        chk("oor_err2_resp", Hresp, 1);
        step();
        Htrans = 2'd0;
        chk("oor_idle_resp", Hresp, 0);
        chk("err2_xfer_ignored", Hreadyout, 1);
        step();
        chk("err2_xfer_no_req", bk_req, 0);
        chk("err2_xfer_still_idle", Hreadyout, 1);

        // asynchronous reset in REQ
        Haddr = 32'h8800_0000; Hwrite = 1'b0; Htrans = 2'd2;
        step();
        Htrans = 2'd0;
        step();
        chk("mid_req_up", bk_req, 1);
        #2 Hresetn = 1'b0;
        #1;
        chk("arst_req", bk_req, 0);
        chk("arst_rdy", Hreadyout, 1);
        chk("arst_sel", bk_sel, 0);
        step();
        Hresetn = 1'b1;
        Haddr = 32'h8800_0004; Hwrite = 1'b1; Htrans = 2'd2;
        step();
        Htrans = 2'd0; Hwdata = 32'h55;
        chk("post_rst_sel", bk_sel, 3'b100);
        chk("post_rst_addr", bk_addr, 32'h8800_0004);
        step();
        chk("post_rst_req", bk_req, 1);
        chk("post_rst_wdata", bk_wdata, 32'h55);
        bk_ack = 1'b1;
        step();
        bk_ack = 1'b0;
        chk("post_rst_done", Hreadyout, 1);
        chk("post_rst_resp", Hresp, 0);
        step();

        // no ack: timeout with the feature, indefinite wait without
        Haddr = 32'h8000_0010; Hwrite = 1'b0; Htrans = 2'd2;
        step();
        Htrans = 2'd0;
        step();
        n = 0;
`ifdef AHB_SLV_TIMEOUT_EN
        while (bk_req && n < 40) begin
            n++;
            step();
        end
        chk("to_req_cycles", n, 16);
        chk("to_err1_rdy", Hreadyout, 0);
        chk("to_err1_resp", Hresp, 1);
        step();
        chk("to_err2_rdy", Hreadyout, 1);
        chk("to_err2_resp", Hresp, 1);
        step();
`else
        while (bk_req && n < 20) begin
            n++;
            step();
        end
        chk("wait_req_held", bk_req, 1);
        chk("wait_rdy_low", Hreadyout, 0);
        bk_ack = 1'b1; bk_rdata = 32'h77;
        step();
        bk_ack = 1'b0;
        chk("wait_done_rdy", Hreadyout, 1);
        chk("wait_hrdata", Hrdata, 32'h77);
        step();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
